// File: rtl/lsu.sv
// Load/store unit: RV32 byte/half/word access to an internal word RAM with a WAIT_CYCLES-deep stall.
// Optional LSU_MISALIGN_CHECK_EN flags misaligned half/word accesses instead of force-aligning them.
module lsu #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misaligned_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          ld_q, st_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [2:0]    acc_f3;
  logic          acc_ld, acc_st, acc_mis;
  logic          ld_ok, st_ok, is_half, is_word, mis_raw;
  logic [1:0]    off;
  logic [AW-1:0] idx;
  logic [31:0]   word, shifted, ld_val, st_data;
  logic [15:0]   half_v;
  logic [3:0]    st_be;
  logic          commit;

  assign req = mem_read_i | mem_write_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      if (state_q == S_IDLE && req) begin
        addr_q  <= addr_i[AW+1:0];
        wdata_q <= wdata_i;
        f3_q    <= funct3_i;
        ld_q    <= mem_read_i;
        st_q    <= mem_write_i & ~mem_read_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o = rst_n_i & (((state_q == S_IDLE) & req) | (state_q == S_WAIT));
  end

  // In IDLE the access is described by the live inputs, afterwards by the captured copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = addr_i[AW+1:0];
      acc_wdata = wdata_i;
      acc_f3    = funct3_i;
      acc_ld    = mem_read_i;
      acc_st    = mem_write_i & ~mem_read_i;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_f3    = f3_q;
      acc_ld    = ld_q;
      acc_st    = st_q;
    end
  end

  always_comb begin
    ld_ok   = acc_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_ok   = acc_f3 inside {3'b000, 3'b001, 3'b010};
    is_half = (acc_f3[1:0] == 2'b01);
    is_word = (acc_f3[1:0] == 2'b10);
`ifdef LSU_MISALIGN_CHECK_EN
    mis_raw = (is_half & acc_addr[0]) | (is_word & (acc_addr[1:0] != 2'b00));
    off     = acc_addr[1:0];
`else
    mis_raw = 1'b0;
    off     = is_word ? 2'b00 : (is_half ? {acc_addr[1], 1'b0} : acc_addr[1:0]);
`endif
    acc_mis = mis_raw & ((acc_ld & ld_ok) | (acc_st & st_ok));
    idx     = acc_addr[AW+1:2];
  end

  always_comb begin
    word    = mem_q[idx];
    shifted = word >> {off, 3'b000};
    half_v  = off[1] ? word[31:16] : word[15:0];
    case (acc_f3)
      3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_val = {{16{half_v[15]}}, half_v};
      3'b010:  ld_val = word;
      3'b100:  ld_val = {24'd0, shifted[7:0]};
      3'b101:  ld_val = {16'd0, half_v};
      default: ld_val = '0;
    endcase
    rdata_d = '0;
    mis_d   = 1'b0;
    if (state_d == S_DONE) begin
      mis_d = acc_mis;
      if (acc_ld && !acc_mis) rdata_d = ld_val;
    end
  end

  always_comb begin
    case (acc_f3[1:0])
      2'b00:   begin st_be = 4'b0001 << off;                 st_data = {4{acc_wdata[7:0]}};  end
      2'b01:   begin st_be = off[1] ? 4'b1100 : 4'b0011;     st_data = {2{acc_wdata[15:0]}}; end
      default: begin st_be = 4'b1111;                        st_data = acc_wdata;            end
    endcase
    commit = (state_q == S_DONE) & acc_st & st_ok & ~acc_mis;
  end

  // RAM is deliberately not reset; a reset in DONE only suppresses the pending commit.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign rdata_o      = rdata_q;
  assign misaligned_o = mis_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: three instances (WAIT_CYCLES 0/2/3) checked against a byte-array reference model.
module tb_lsu;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        mem_read  [3];
  logic        mem_write [3];
  logic [2:0]  f3        [3];
  logic [31:0] addr      [3];
  logic [31:0] wdata     [3];
  logic [31:0] rdata     [3];
  logic        stall     [3];
  logic        mis       [3];

  logic [7:0]  mm [3][1024];
  int          total = 0;
  int          bad   = 0;
  int          cycle_cnt = 0;
  int          waits [3] = '{0, 2, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  lsu #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .mem_read_i(mem_read[0]), .mem_write_i(mem_write[0]),
    .funct3_i(f3[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
    .rdata_o(rdata[0]), .stall_o(stall[0]), .misaligned_o(mis[0]));
  lsu #(.DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .mem_read_i(mem_read[1]), .mem_write_i(mem_write[1]),
    .funct3_i(f3[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
    .rdata_o(rdata[1]), .stall_o(stall[1]), .misaligned_o(mis[1]));
  lsu #(.DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_n_i(rst_n[2]), .mem_read_i(mem_read[2]), .mem_write_i(mem_write[2]),
    .funct3_i(f3[2]), .addr_i(addr[2]), .wdata_i(wdata[2]),
    .rdata_o(rdata[2]), .stall_o(stall[2]), .misaligned_o(mis[2]));

  // Reference: byte-addressed memory, RV32 load/store rules applied directly.
  function automatic void model(input int k, input logic rd, input logic wr, input logic [2:0] fn,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] er, output logic em);
    int n, ea;
    logic ld, st, vld_ld, vld_st;
    logic [31:0] v;
    ld = rd;
    st = wr && !rd;
    n  = (fn[1:0] == 2'd2) ? 4 : ((fn[1:0] == 2'd1) ? 2 : 1);
    vld_ld = fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    vld_st = fn inside {3'd0, 3'd1, 3'd2};
    ea = int'(a % 32'd1024);
    em = MIS && ((ld && vld_ld) || (st && vld_st)) && (ea % n != 0);
    if (!MIS) ea = ea - ea % n;
    er = 32'd0;
    if (ld && vld_ld && !em) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(mm[k][ea+i]) << (8*i));
      if (n < 4 && fn[2] == 1'b0 && mm[k][ea+n-1][7]) v = v | (32'hFFFF_FFFF << (8*n));
      er = v;
    end
    if (st && vld_st && !em)
      for (int i = 0; i < n; i++) mm[k][ea+i] = 8'(wd >> (8*i));
  endfunction

  // One complete handshake; returns what was seen in the DONE cycle and how long stall was high.
  task automatic access(input int k, input logic rd, input logic wr, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] ord, output logic omis, output int cyc);
    @(negedge clk);
    mem_read[k] = rd; mem_write[k] = wr; f3[k] = fn; addr[k] = a; wdata[k] = wd;
    cyc = 0;
    #1;
    while (stall[k] === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    ord  = rdata[k];
    omis = mis[k];
    mem_read[k] = 1'b0; mem_write[k] = 1'b0;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; mem_read[k] = 1'b0; mem_write[k] = 1'b0;
      f3[k] = 3'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) mem_read[k] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (stall[k] !== 1'b0 || rdata[k] !== 32'd0 || mis[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d]: stall=%b rdata=%h mis=%b, required 0/0/0", k, stall[k], rdata[k], mis[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin mem_read[k] = 1'b0; rst_n[k] = 1'b1; end
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (stall[k] !== 1'b0 || rdata[k] !== 32'd0) begin
        bad++;
        $display("FAIL idle_after_reset[%0d]: stall=%b rdata=%h", k, stall[k], rdata[k]);
      end
    end
  endtask

  logic        d_rd [10] = '{0, 1, 1, 1, 1, 1, 0, 1, 0, 1};
  logic        d_wr [10] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0};
  logic [2:0]  d_f3 [10] = '{2, 2, 0, 4, 1, 5, 0, 2, 1, 2};
  logic [31:0] d_a  [10] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h10, 32'h12, 32'h10};
  logic [31:0] d_wd [10] = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 32'hAAAAAA55, 0, 32'hFFFF1234, 0};
  logic [31:0] d_ex [10] = '{0, 32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                             32'h0000BEEF, 0, 32'hDEAD55EF, 0, 32'h123455EF};

  task automatic test_directed;
    logic [31:0] r; logic m; int c;
    for (int i = 0; i < 10; i++) begin
      access(0, d_rd[i], d_wr[i], d_f3[i], d_a[i], d_wd[i], r, m, c);
      total++;
      if (r !== d_ex[i] || m !== 1'b0 || c != 1) begin
        bad++;
        $display("FAIL directed[%0d]: rdata=%h mis=%b stall_cycles=%0d, required %h/0/1", i, r, m, c, d_ex[i]);
      end
    end
  endtask

`ifdef LSU_MISALIGN_CHECK_EN
  logic        m_rd [5] = '{1, 0, 1, 1, 1};
  logic [2:0]  m_f3 [5] = '{2, 2, 2, 5, 3};
  logic [31:0] m_a  [5] = '{32'h12, 32'h11, 32'h10, 32'h13, 32'h10};
  logic [31:0] m_ex [5] = '{0, 0, 32'h123455EF, 0, 0};
  logic        m_mx [5] = '{1, 1, 0, 1, 0};
`else
  logic        m_rd [5] = '{1, 1, 1, 1, 1};
  logic [2:0]  m_f3 [5] = '{2, 5, 0, 2, 3};
  logic [31:0] m_a  [5] = '{32'h12, 32'h13, 32'h12, 32'h11, 32'h10};
  logic [31:0] m_ex [5] = '{32'h123455EF, 32'h00001234, 32'h00000034, 32'h123455EF, 0};
  logic        m_mx [5] = '{0, 0, 0, 0, 0};
`endif

  task automatic test_misalign;
    logic [31:0] r; logic m; int c;
    for (int i = 0; i < 5; i++) begin
      access(0, m_rd[i], !m_rd[i], m_f3[i], m_a[i], 32'hFFFFFFFF, r, m, c);
      total++;
      if (r !== m_ex[i] || m !== m_mx[i] || c != 1) begin
        bad++;
        $display("FAIL misalign[%0d]: rdata=%h mis=%b cycles=%0d, required %h/%b/1", i, r, m, c, m_ex[i], m_mx[i]);
      end
    end
  endtask

  task automatic test_wrap_latency;
    logic [31:0] r; logic m; int c;
    access(1, 1'b0, 1'b1, 3'd2, 32'h400, 32'h5A5A1234, r, m, c);
    total++;
    if (c != 3 || r !== 32'd0) begin
      bad++;
      $display("FAIL wrap_store: cycles=%0d rdata=%h, required 3/0", c, r);
    end
    access(1, 1'b1, 1'b0, 3'd2, 32'h000, 32'd0, r, m, c);
    total++;
    if (c != 3 || r !== 32'h5A5A1234) begin
      bad++;
      $display("FAIL wrap_load: cycles=%0d rdata=%h, required 3/5a5a1234", c, r);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r, ex [4]; logic m; int c, t_prev;
    logic [31:0] a_t [4] = '{32'h200, 32'h204, 32'h200, 32'h204};
    logic        w_t [4] = '{1, 1, 0, 0};
    ex = '{0, 0, 32'h01020304, 32'hA0B0C0D0};
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      access(1, !w_t[i], w_t[i], 3'd2, a_t[i], (i == 0) ? 32'h01020304 : 32'hA0B0C0D0, r, m, c);
      total++;
      if (r !== ex[i] || c != 3 || (i > 0 && cycle_cnt - t_prev != 4)) begin
        bad++;
        $display("FAIL b2b[%0d]: rdata=%h cycles=%0d gap=%0d, required %h/3/4", i, r, c, cycle_cnt - t_prev, ex[i]);
      end
      t_prev = cycle_cnt;
    end
    @(negedge clk);
    #1;
    total++;
    if (rdata[1] !== 32'd0 || stall[1] !== 1'b0) begin
      bad++;
      $display("FAIL rdata_clear: rdata=%h stall=%b, required 0/0", rdata[1], stall[1]);
    end
  endtask

  task automatic test_random(input int k, input int n);
    logic [31:0] r, er, a, wd; logic m, em, rd, wr; logic [2:0] fn; int c, sel;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model(k, 1'b0, 1'b1, 3'd2, 32'(4*i), wd, er, em);
      access(k, 1'b0, 1'b1, 3'd2, 32'(4*i), wd, r, m, c);
    end
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 7);
      rd  = (sel < 4) || (sel == 7);
      wr  = (sel >= 4);
      fn  = 3'($urandom_range(0, 7));
      a   = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      wd  = $urandom;
      model(k, rd, wr, fn, a, wd, er, em);
      access(k, rd, wr, fn, a, wd, r, m, c);
      total++;
      if (r !== er || m !== em || c != waits[k] + 1) begin
        bad++;
        $display("FAIL rand[%0d.%0d] rd=%b wr=%b f3=%0d a=%h: rdata=%h mis=%b cycles=%0d, required %h/%b/%0d",
                 k, i, rd, wr, fn, a, r, m, c, er, em, waits[k] + 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; logic m; int c;
    access(2, 1'b0, 1'b1, 3'd2, 32'h20, 32'h11111111, r, m, c);
    @(negedge clk);
    mem_write[2] = 1'b1; f3[2] = 3'd2; addr[2] = 32'h20; wdata[2] = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (stall[2] !== 1'b0 || rdata[2] !== 32'd0) begin
      bad++;
      $display("FAIL reset_in_wait: stall=%b rdata=%h, required 0/0", stall[2], rdata[2]);
    end
    rst_n[2] = 1'b1; mem_write[2] = 1'b0;
    access(2, 1'b1, 1'b0, 3'd2, 32'h20, 32'd0, r, m, c);
    total++;
    if (r !== 32'h11111111 || c != 4) begin
      bad++;
      $display("FAIL after_wait_reset: rdata=%h cycles=%0d, required 11111111/4", r, c);
    end
    @(negedge clk);
    mem_write[2] = 1'b1; f3[2] = 3'd2; addr[2] = 32'h20; wdata[2] = 32'hCAFEF00D;
    c = 0;
    #1;
    while (stall[2] === 1'b1 && c < 40) begin c++; @(negedge clk); #1; end
    rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1; mem_write[2] = 1'b0;
    access(2, 1'b1, 1'b0, 3'd2, 32'h20, 32'd0, r, m, c);
    total++;
    if (r !== 32'h11111111) begin
      bad++;
      $display("FAIL after_done_reset: rdata=%h, required 11111111", r);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misalign();
    test_wrap_latency();
    test_back_to_back();
    test_random(0, 150);
    test_random(1, 60);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
